// File: rtl/tt_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tt_pwm_bank
//  Description : Multi-channel PWM generator with a shared prescaled period
//                counter. Duty, period and prescale are written to staging
//                registers and copied into shadow registers only at a period
//                boundary (counter wrap or sync_load), so an output never
//                changes shape in the middle of a period. The enable and
//                invert masks act immediately.
//
//  Ports       : clk          - clock
//                rst          - synchronous reset, active-high
//                ena          - counting enable; low freezes counters/outputs
//                sync_load    - force shadow load and restart the period
//                wr_en        - register write strobe
//                wr_addr      - register address
//                                 0..NUM_CH-1 duty[i], NUM_CH top,
//                                 NUM_CH+1 presc, NUM_CH+2 en_mask,
//                                 NUM_CH+3 inv_mask
//                wr_data      - register write data
//                pwm_out      - registered PWM outputs
//                period_start - pulse in the cycle the counter reads 0
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_pwm_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(NUM_CH + 4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              sync_load,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam logic [ADDR_W-1:0] c_addr_top   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] c_addr_presc = ADDR_W'(NUM_CH + 1);
    localparam logic [ADDR_W-1:0] c_addr_en    = ADDR_W'(NUM_CH + 2);
    localparam logic [ADDR_W-1:0] c_addr_inv   = ADDR_W'(NUM_CH + 3);
    localparam logic [WIDTH-1:0]  c_one        = WIDTH'(1);

    // Staging registers (written by the host)
    logic [WIDTH-1:0]  r_duty [NUM_CH];
    logic [WIDTH-1:0]  r_top;
    logic [WIDTH-1:0]  r_presc;
    logic [NUM_CH-1:0] r_en_mask;
    logic [NUM_CH-1:0] r_inv_mask;

    // Shadow registers (govern the running period)
    logic [WIDTH-1:0]  r_duty_sh [NUM_CH];
    logic [WIDTH-1:0]  r_top_sh;
    logic [WIDTH-1:0]  r_presc_sh;

    // Counters
    logic [WIDTH-1:0]  r_presc_cnt;
    logic [WIDTH-1:0]  r_cnt;

    logic              w_tick;
    logic              w_wrap;
    logic              w_load;
    logic [NUM_CH-1:0] w_pwm_next;

    assign w_tick = ena && (r_presc_cnt == r_presc_sh);
    assign w_wrap = w_tick && (r_cnt == r_top_sh);
    assign w_load = sync_load || w_wrap;

    // Host writes land in staging only; a write coinciding with a boundary
    // is picked up at the following boundary because the shadow copy below
    // samples the pre-write staging value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= '0;
            end
            r_top      <= '1;
            r_presc    <= '0;
            r_en_mask  <= '0;
            r_inv_mask <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    r_duty[i] <= wr_data;
                end
            end
            if (wr_addr == c_addr_top)   r_top      <= wr_data;
            if (wr_addr == c_addr_presc) r_presc    <= wr_data;
            if (wr_addr == c_addr_en)    r_en_mask  <= wr_data[NUM_CH-1:0];
            if (wr_addr == c_addr_inv)   r_inv_mask <= wr_data[NUM_CH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= '0;
            end
            r_top_sh   <= '1;
            r_presc_sh <= '0;
        end else if (w_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= r_duty[i];
            end
            r_top_sh   <= r_top;
            r_presc_sh <= r_presc;
        end
    end

    // Prescaler and period counter. sync_load overrides ena so a stalled
    // bank can still be realigned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_cnt  <= '0;
            r_cnt        <= '0;
            period_start <= 1'b0;
        end else if (sync_load) begin
            r_presc_cnt  <= '0;
            r_cnt        <= '0;
            period_start <= 1'b1;
        end else if (w_tick) begin
            r_presc_cnt  <= '0;
            r_cnt        <= w_wrap ? '0 : (r_cnt + c_one);
            period_start <= w_wrap;
        end else begin
            if (ena) begin
                r_presc_cnt <= r_presc_cnt + c_one;
            end
            period_start <= 1'b0;
        end
    end

    // Compare against the shadow duty; a disabled channel is forced low
    // before inversion could make it high.
    always_comb begin
        w_pwm_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pwm_next[i] = r_en_mask[i] & ((r_cnt < r_duty_sh[i]) ^ r_inv_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else if (ena) begin
            pwm_out <= w_pwm_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_pwm_bank
//  Description : Scoreboard bench for tt_pwm_bank. Each driven cycle runs a
//                behavioural model of the bank and queues the expected
//                {period_start, pwm_out}; a monitor pops and compares after
//                every clock edge. Directed scenarios followed by random
//                traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_pwm_bank;

    localparam int NUM_CH = 5;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = $clog2(NUM_CH + 4);

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              sync_load;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    tt_pwm_bank #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sync_load    (sync_load),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cycle = 0;

    logic [NUM_CH:0] exp_q[$];

    // ---------------- behavioural model ----------------
    int                m_duty [NUM_CH];   // staged
    int                a_duty [NUM_CH];   // active for the running period
    int                m_top, a_top, m_presc, a_presc;
    logic [NUM_CH-1:0] m_en, m_inv;
    int                m_sub;             // cycles elapsed in the current tick
    int                m_pos;             // tick position in the period
    logic [NUM_CH-1:0] m_pwm;
    bit                m_ps;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 0;
            a_duty[i] = 0;
        end
        m_top   = (1 << WIDTH) - 1;
        a_top   = m_top;
        m_presc = 0;
        a_presc = 0;
        m_en    = '0;
        m_inv   = '0;
        m_sub   = 0;
        m_pos   = 0;
        m_pwm   = '0;
        m_ps    = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit e, input bit s,
                              input bit w, input int addr, input int data);
        bit tick_now;
        bit boundary;
        if (r) begin
            model_reset();
        end else begin
            // Outputs reflect the position held before this edge.
            if (e) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_en[i]) m_pwm[i] = (m_pos < a_duty[i]) ? ~m_inv[i] : m_inv[i];
                    else         m_pwm[i] = 1'b0;
                end
            end
            tick_now = e && (m_sub == a_presc);
            boundary = s || (tick_now && (m_pos == a_top));
            if (s) begin
                m_sub = 0;
                m_pos = 0;
                m_ps  = 1'b1;
            end else if (tick_now) begin
                m_sub = 0;
                m_pos = (m_pos == a_top) ? 0 : m_pos + 1;
                m_ps  = boundary;
            end else begin
                if (e) m_sub = m_sub + 1;
                m_ps = 1'b0;
            end
            if (boundary) begin
                for (int i = 0; i < NUM_CH; i++) a_duty[i] = m_duty[i];
                a_top   = m_top;
                a_presc = m_presc;
            end
            if (w) begin
                if (addr < NUM_CH)           m_duty[addr] = data % (1 << WIDTH);
                else if (addr == NUM_CH)     m_top   = data % (1 << WIDTH);
                else if (addr == NUM_CH + 1) m_presc = data % (1 << WIDTH);
                else if (addr == NUM_CH + 2) m_en    = NUM_CH'(data);
                else if (addr == NUM_CH + 3) m_inv   = NUM_CH'(data);
            end
        end
    endtask

    // ---------------- driver ----------------
    bit cur_ena = 1'b0;

    task automatic drive(input bit r, input bit e, input bit s,
                         input bit w, input int addr, input int data);
        rst       = r;
        ena       = e;
        sync_load = s;
        wr_en     = w;
        wr_addr   = ADDR_W'(addr);
        wr_data   = WIDTH'(data);
        model_step(r, e, s, w, addr, data);
        exp_q.push_back({m_ps, m_pwm});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, cur_ena, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic wr(input int addr, input int data);
        drive(1'b0, cur_ena, 1'b0, 1'b1, addr, data);
    endtask

    task automatic do_sync();
        drive(1'b0, cur_ena, 1'b1, 1'b0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [NUM_CH:0] exp_v;
        logic [NUM_CH:0] got_v;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            got_v = {period_start, pwm_out};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got %b, no expected entry queued", n_cycle, got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: {period_start,pwm_out} got %b expected %b",
                             n_cycle, got_v, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        // Reset, then defaults: all outputs low, period_start every 256.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        cur_ena = 1'b1;
        idle(600);

        // 3 high / 7 low on channel 0.
        wr(NUM_CH, 9);
        wr(0, 3);
        wr(NUM_CH + 2, 1);
        do_sync();
        idle(25);

        // Change duty at cnt=5: current period unaffected.
        for (int k = 0; k < 20 && m_pos != 5; k++) idle(1);
        wr(0, 7);
        idle(30);

        // Prescaled period on channel 1, then invert it.
        wr(NUM_CH + 1, 2);
        wr(NUM_CH, 3);
        wr(1, 2);
        wr(NUM_CH + 2, 3);
        do_sync();
        idle(37);
        wr(NUM_CH + 3, 2);
        idle(30);

        // Constant-low and constant-high channels.
        wr(NUM_CH + 3, 0);
        wr(NUM_CH + 1, 0);
        wr(NUM_CH, 9);
        wr(2, 0);
        wr(3, 10);
        wr(NUM_CH + 2, 5'h1f);
        do_sync();
        idle(25);

        // Unmapped addresses must not disturb anything.
        wr(NUM_CH + 4, 8'h5a);
        wr(15, 8'hff);
        idle(25);

        // Freeze mid-period.
        idle(4);
        cur_ena = 1'b0;
        idle(5);
        cur_ena = 1'b1;
        idle(25);

        // Write at the same edge as a sync_load.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 1);
        idle(25);

        // Reset mid-period.
        idle(3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(20);

        // Random traffic.
        for (int k = 0; k < 2500; k++) begin
            int  a;
            int  d;
            bit  r;
            bit  e;
            bit  s;
            bit  w;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 99) < 85);
            s = ($urandom_range(0, 59) == 0);
            w = ($urandom_range(0, 99) < 20);
            a = $urandom_range(0, 15);
            if (a == NUM_CH)          d = $urandom_range(0, 15);
            else if (a == NUM_CH + 1) d = $urandom_range(0, 3);
            else if (a < NUM_CH)      d = $urandom_range(0, 18);
            else                      d = $urandom_range(0, 255);
            drive(r, e, s, w, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
